// File: rtl/im_fetch_pkg.sv
// im_fetch_pkg: shared state encoding and default geometry for the IM fetch sequencer
package im_fetch_pkg;
  localparam int WL_DEF = 32;
  localparam int DEPTH_DEF = 13;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, END = 2'd2} state_t;
endpackage

// File: rtl/fetch_q.sv
// fetch_q: 2-entry FIFO with a registered head
// ports: clk, rst_n (async active-low), push/din write, pop consume head,
//        flush drops all entries, count occupancy, head oldest entry
module fetch_q #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;
  logic         pop_ok;
  logic [1:0]   slot;
  // slot is where an incoming word lands once this cycle's pop has shifted the queue
  always_comb begin
    pop_ok = pop && count != 2'd0;
    slot = count - {1'b0, pop_ok};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= slot + {1'b0, push};
      if (push && slot == 2'd0) head <= din;
      else if (pop_ok && count == 2'd2) head <= tail;
      if (push && slot == 2'd1) tail <= din;
    end
  end
endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: PC sequencer feeding IM words into a 2-entry queue toward decode
// ports: clk, rst_n (async active-low), start, ima/imrd IM address/data,
//        br_en/br_tgt redirect, if_valid/if_ready/if_instr/if_pc decode handshake, done
module im_fetch_ctrl
  import im_fetch_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [WL-1:0] ima,
  input  logic [WL-1:0] imrd,
  input  logic          br_en,
  input  logic [WL-1:0] br_tgt,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [WL-1:0] if_instr,
  output logic [WL-1:0] if_pc,
  output logic          done
);
  state_t        state;
  logic [WL-1:0] pc;
  logic [1:0]    count;
  logic          pop;
  logic          push;
  logic          flush;
  logic          in_range;
  always_comb begin
    in_range = pc < WL'(DEPTH);
    pop = if_valid && if_ready;
    flush = br_en && state != IDLE;
    push = state == RUN && in_range && !br_en && (count != 2'd2 || pop);
  end
  assign ima = pc;
  assign if_valid = count != 2'd0;
  fetch_q #(.W(2 * WL)) q (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din({pc, imrd}),
    .count(count),
    .head({if_pc, if_instr})
  );
  // a redirect outranks both the push and the out-of-range transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= WL'(RESET_PC);
      done <= 1'b0;
    end else begin
      done <= state == END && count == 2'd0 && !br_en;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          pc <= WL'(RESET_PC);
        end
      end else if (br_en) begin
        pc <= br_tgt;
        state <= br_tgt < WL'(DEPTH) ? RUN : END;
      end else if (state == RUN) begin
        if (!in_range) state <= END;
        else if (push) pc <= pc + WL'(1);
      end else if (state != END) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_im_fetch_ctrl.sv
// tb_im_fetch_ctrl: directed checks of fetch ordering, back-pressure, redirect, end and reset
module tb_im_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] ima;
  logic [31:0] imrd;
  logic        br_en;
  logic [31:0] br_tgt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        done;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] TAG = 32'hA500_0000;
  im_fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ima(ima),
    .imrd(imrd),
    .br_en(br_en),
    .br_tgt(br_tgt),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .done(done)
  );
  assign imrd = TAG ^ ima;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic head(input string tag, input logic [31:0] p);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, p);
    chk({tag, "_instr"}, if_instr, TAG ^ p);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    br_en = 1'b0;
    br_tgt = '0;
    if_ready = 1'b0;
    tick();
    tick();
    chk("rst_ima", ima, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    br_en = 1'b1;
    br_tgt = 32'd5;
    tick();
    br_en = 1'b0;
    chk("idle_br_ima", ima, 32'd0);
    chk("idle_br_state", {30'd0, dut.state}, 32'd0);
    tick();
    chk("idle_br_valid", {31'd0, if_valid}, 32'd0);
    if_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid0", {31'd0, if_valid}, 32'd0);
    chk("start_ima", ima, 32'd0);
    for (int i = 0; i < 13; i++) begin
      tick();
      head("stream", i);
    end
    tick();
    chk("end_valid", {31'd0, if_valid}, 32'd0);
    chk("end_ima", ima, 32'd13);
    chk("end_state", {30'd0, dut.state}, 32'd2);
    chk("end_done0", {31'd0, done}, 32'd0);
    tick();
    chk("end_done1", {31'd0, done}, 32'd1);
    tick();
    chk("end_ima_hold", ima, 32'd13);
    br_en = 1'b1;
    br_tgt = 32'd0;
    tick();
    br_en = 1'b0;
    chk("rerun_ima", ima, 32'd0);
    chk("rerun_done", {31'd0, done}, 32'd0);
    tick();
    head("bp0", 0);
    tick();
    head("bp1", 1);
    if_ready = 1'b0;
    tick();
    head("bp_hold1", 1);
    chk("bp_ima3", ima, 32'd3);
    tick();
    chk("bp_full_ima", ima, 32'd3);
    chk("bp_count", {30'd0, dut.count}, 32'd2);
    tick();
    head("bp_hold2", 1);
    chk("bp_full_ima2", ima, 32'd3);
    if_ready = 1'b1;
    tick();
    head("rel2", 2);
    chk("rel_ima", ima, 32'd4);
    tick();
    head("rel3", 3);
    tick();
    head("rel4", 4);
    chk("pre_br_count", {30'd0, dut.count}, 32'd2);
    br_en = 1'b1;
    br_tgt = 32'd7;
    tick();
    br_en = 1'b0;
    chk("br_bubble", {31'd0, if_valid}, 32'd0);
    chk("br_ima", ima, 32'd7);
    tick();
    head("br7", 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    head("run_start8", 8);
    chk("run_start_ima", ima, 32'd9);
    br_en = 1'b1;
    br_tgt = 32'd20;
    tick();
    br_en = 1'b0;
    chk("oob_valid", {31'd0, if_valid}, 32'd0);
    chk("oob_ima", ima, 32'd20);
    chk("oob_state", {30'd0, dut.state}, 32'd2);
    tick();
    chk("oob_done", {31'd0, done}, 32'd1);
    chk("oob_ima_hold", ima, 32'd20);
    br_en = 1'b1;
    br_tgt = 32'd3;
    tick();
    br_en = 1'b0;
    chk("ret_done", {31'd0, done}, 32'd0);
    chk("ret_ima", ima, 32'd3);
    tick();
    head("ret3", 3);
    tick();
    head("ret4", 4);
    tick();
    head("ret5", 5);
    if_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", {30'd0, dut.count}, 32'd2);
    chk("pre_rst_ima", ima, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_ima", ima, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_state", {30'd0, dut.state}, 32'd0);
    tick();
    rst_n = 1'b1;
    if_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("post_rst_ima", ima, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    head("resume0", 0);
    tick();
    head("resume1", 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
